// File: rtl/fc_feeder.sv
// fc_feeder: transmitter side of the fully-connected layer input interface.
//
// Buffers one pooled feature vector (N_BEATS words x 6 signed channels) and
// N_WEIGHTS signed weights. On an accepted start it serially loads the weights
// into the fc block (weight_en/weight), waits one settle cycle, then streams
// the feature words on din_0..din_5 with ivalid pulsed every other cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   feat_wr_en, feat_wr_0..5 write one 6-channel feature word (IDLE only)
//   wt_wr_en, wt_wr_data     write one weight (IDLE only)
//   start, skip_wload        begin a run; skip_wload sampled with start
//   feat_full, wt_full       buffer fill flags
//   busy, done, start_err    run status (done/start_err are 1-cycle pulses)
//   weight_en, weight        weight strobe/value to fc
//   ivalid, din_0..din_5     feature word strobe/value to fc
//
// Transfer semantics: there is no back-pressure. A weight transfers in every
// cycle weight_en is 1, a feature word in every cycle ivalid is 1; the fc
// block must accept it in that cycle. Buffer writes have no ready either:
// a write is taken only in IDLE with room in the buffer, otherwise dropped.
//
// Every output comes straight from a flop. Output next-values are derived
// from the next state/index so they line up with the state they describe.

module fc_feeder #(
  parameter int DATA_W    = 8,
  parameter int N_BEATS   = 32,
  parameter int N_WEIGHTS = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              feat_wr_en,
  input  logic [DATA_W-1:0] feat_wr_0,
  input  logic [DATA_W-1:0] feat_wr_1,
  input  logic [DATA_W-1:0] feat_wr_2,
  input  logic [DATA_W-1:0] feat_wr_3,
  input  logic [DATA_W-1:0] feat_wr_4,
  input  logic [DATA_W-1:0] feat_wr_5,
  input  logic              wt_wr_en,
  input  logic [DATA_W-1:0] wt_wr_data,
  input  logic              start,
  input  logic              skip_wload,
  output logic              feat_full,
  output logic              wt_full,
  output logic              busy,
  output logic              done,
  output logic              start_err,
  output logic              weight_en,
  output logic [DATA_W-1:0] weight,
  output logic              ivalid,
  output logic [DATA_W-1:0] din_0,
  output logic [DATA_W-1:0] din_1,
  output logic [DATA_W-1:0] din_2,
  output logic [DATA_W-1:0] din_3,
  output logic [DATA_W-1:0] din_4,
  output logic [DATA_W-1:0] din_5
);

  localparam int WORD_W  = 6 * DATA_W;
  localparam int FC_W    = $clog2(N_BEATS + 1);
  localparam int WC_W    = $clog2(N_WEIGHTS + 1);
  localparam int FA_W    = $clog2(N_BEATS);
  localparam int WA_W    = $clog2(N_WEIGHTS);
  localparam int IDX_MAX = (N_WEIGHTS > N_BEATS) ? N_WEIGHTS : N_BEATS;
  localparam int IDX_W   = $clog2(IDX_MAX);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_W   = 3'd1,
    S_SETTLE   = 3'd2,
    S_FEED     = 3'd3,
    S_FEED_GAP = 3'd4,
    S_FIN      = 3'd5
  } state_e;

  // Buffers: contents are don't-care after reset, so no reset on them.
  logic [WORD_W-1:0] feat_mem [N_BEATS];
  logic [DATA_W-1:0] wt_mem   [N_WEIGHTS];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FC_W-1:0]   feat_cnt_q, feat_cnt_d;
  logic [WC_W-1:0]   wt_cnt_q, wt_cnt_d;

  logic              feat_full_q, feat_full_d;
  logic              wt_full_q, wt_full_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_err_q, start_err_d;
  logic              weight_en_q, weight_en_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic              ivalid_q, ivalid_d;
  logic [WORD_W-1:0] din_q, din_d;

  logic              feat_is_full;
  logic              wt_is_full;
  logic              feat_wr_ok;
  logic              wt_wr_ok;
  logic              start_rej;
  logic [FA_W-1:0]   feat_wr_addr;
  logic [WA_W-1:0]   wt_wr_addr;

  // Start decisions use the pre-write counts of this edge.
  assign feat_is_full = (feat_cnt_q == FC_W'(N_BEATS));
  assign wt_is_full   = (wt_cnt_q == WC_W'(N_WEIGHTS));
  assign feat_wr_ok   = (state_q == S_IDLE) && feat_wr_en && !feat_is_full;
  assign wt_wr_ok     = (state_q == S_IDLE) && wt_wr_en && !wt_is_full;
  assign feat_wr_addr = feat_cnt_q[FA_W-1:0];
  assign wt_wr_addr   = wt_cnt_q[WA_W-1:0];

  // ---------------------------------------------------------------------
  // Buffer storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (feat_wr_ok) begin
      feat_mem[feat_wr_addr] <= {feat_wr_5, feat_wr_4, feat_wr_3,
                                 feat_wr_2, feat_wr_1, feat_wr_0};
    end
    if (wt_wr_ok) begin
      wt_mem[wt_wr_addr] <= wt_wr_data;
    end
  end

  // Fill counters: the feature vector is consumed by a run, weights persist.
  always_comb begin
    feat_cnt_d = feat_cnt_q;
    wt_cnt_d   = wt_cnt_q;
    if (state_q == S_FIN) begin
      feat_cnt_d = '0;
    end else if (feat_wr_ok) begin
      feat_cnt_d = feat_cnt_q + FC_W'(1);
    end
    if (wt_wr_ok) begin
      wt_cnt_d = wt_cnt_q + WC_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      feat_cnt_q <= '0;
      wt_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      feat_cnt_q <= feat_cnt_d;
      wt_cnt_q   <= wt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. idx counts weights in LOAD_W and beats in FEED.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_rej = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (feat_is_full && (skip_wload || wt_is_full)) begin
            state_d = skip_wload ? S_FEED : S_LOAD_W;
            idx_d   = '0;
          end else begin
            start_rej = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        if (idx_q == IDX_W'(N_WEIGHTS - 1)) begin
          state_d = S_SETTLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SETTLE: begin
        state_d = S_FEED;
        idx_d   = '0;
      end
      S_FEED: begin
        // The gap after the last beat is the FIN cycle itself.
        state_d = (idx_q == IDX_W'(N_BEATS - 1)) ? S_FIN : S_FEED_GAP;
      end
      S_FEED_GAP: begin
        state_d = S_FEED;
        idx_d   = idx_q + IDX_W'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (next values, registered below)
  // ---------------------------------------------------------------------
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    start_err_d = start_rej;
    weight_en_d = (state_d == S_LOAD_W);
    weight_d    = '0;
    ivalid_d    = (state_d == S_FEED);
    din_d       = '0;
    feat_full_d = (feat_cnt_d == FC_W'(N_BEATS));
    wt_full_d   = (wt_cnt_d == WC_W'(N_WEIGHTS));
    if (state_d == S_LOAD_W) begin
      weight_d = wt_mem[idx_d[WA_W-1:0]];
    end
    if (state_d == S_FEED) begin
      din_d = feat_mem[idx_d[FA_W-1:0]];
    end else if ((state_d == S_FEED_GAP) || (state_d == S_FIN)) begin
      din_d = din_q;  // hold the last beat through its gap cycle
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_full_q <= 1'b0;
      wt_full_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      weight_en_q <= 1'b0;
      weight_q    <= '0;
      ivalid_q    <= 1'b0;
      din_q       <= '0;
    end else begin
      feat_full_q <= feat_full_d;
      wt_full_q   <= wt_full_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      weight_en_q <= weight_en_d;
      weight_q    <= weight_d;
      ivalid_q    <= ivalid_d;
      din_q       <= din_d;
    end
  end

  assign feat_full = feat_full_q;
  assign wt_full   = wt_full_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign start_err = start_err_q;
  assign weight_en = weight_en_q;
  assign weight    = weight_q;
  assign ivalid    = ivalid_q;
  assign din_0     = din_q[0*DATA_W +: DATA_W];
  assign din_1     = din_q[1*DATA_W +: DATA_W];
  assign din_2     = din_q[2*DATA_W +: DATA_W];
  assign din_3     = din_q[3*DATA_W +: DATA_W];
  assign din_4     = din_q[4*DATA_W +: DATA_W];
  assign din_5     = din_q[5*DATA_W +: DATA_W];

endmodule

// File: tb/tb_fc_feeder.sv
// Testbench for fc_feeder: start-acceptance vector table plus directed
// multi-cycle sequences (full run, skip run, mid-run reset, saturation).

module tb_fc_feeder;

  logic       clk;
  logic       rst;
  logic       feat_wr_en;
  logic [7:0] feat_wr_0, feat_wr_1, feat_wr_2, feat_wr_3, feat_wr_4, feat_wr_5;
  logic       wt_wr_en;
  logic [7:0] wt_wr_data;
  logic       start;
  logic       skip_wload;
  logic       feat_full, wt_full, busy, done, start_err, weight_en, ivalid;
  logic [7:0] weight;
  logic [7:0] din_0, din_1, din_2, din_3, din_4, din_5;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [47:0] exp_q[$];
  logic [7:0]  wexp_q[$];

  fc_feeder dut (
    .clk(clk), .rst(rst),
    .feat_wr_en(feat_wr_en),
    .feat_wr_0(feat_wr_0), .feat_wr_1(feat_wr_1), .feat_wr_2(feat_wr_2),
    .feat_wr_3(feat_wr_3), .feat_wr_4(feat_wr_4), .feat_wr_5(feat_wr_5),
    .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data),
    .start(start), .skip_wload(skip_wload),
    .feat_full(feat_full), .wt_full(wt_full), .busy(busy), .done(done),
    .start_err(start_err), .weight_en(weight_en), .weight(weight),
    .ivalid(ivalid),
    .din_0(din_0), .din_1(din_1), .din_2(din_2),
    .din_3(din_3), .din_4(din_4), .din_5(din_5)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    feat_wr_en = 1'b0; wt_wr_en = 1'b0; start = 1'b0; skip_wload = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- data patterns ----------------
  function automatic logic [7:0] fval(input int pat, input int k, input int c);
    int v;
    case (pat)
      0:       v = 6 * k + c - 96;
      1:       v = (6 * k + c - 96) ^ 'h5A;
      default: v = 'h55;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [7:0] wval(input int pat, input int i);
    int v;
    case (pat)
      0:       v = 1;
      1:       v = i - 96;
      default: v = 7;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [47:0] fword(input int pat, input int k);
    logic [47:0] w;
    for (int c = 0; c < 6; c++) w[c*8 +: 8] = fval(pat, k, c);
    return w;
  endfunction

  function automatic int sum6(input logic [47:0] w);
    int s;
    s = 0;
    for (int c = 0; c < 6; c++) s += int'($signed(w[c*8 +: 8]));
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_word(input int pat, input int k);
    feat_wr_0 = fval(pat, k, 0); feat_wr_1 = fval(pat, k, 1);
    feat_wr_2 = fval(pat, k, 2); feat_wr_3 = fval(pat, k, 3);
    feat_wr_4 = fval(pat, k, 4); feat_wr_5 = fval(pat, k, 5);
  endtask

  task automatic fill_feats(input int first, input int n, input int pat);
    for (int k = first; k < first + n; k++) begin
      feat_wr_en = 1'b1;
      set_word(pat, k);
      tick();
    end
    feat_wr_en = 1'b0;
  endtask

  task automatic fill_wts(input int first, input int n, input int pat);
    for (int i = first; i < first + n; i++) begin
      wt_wr_en   = 1'b1;
      wt_wr_data = wval(pat, i);
      tick();
    end
    wt_wr_en = 1'b0;
  endtask

  task automatic push_exp(input int fpat, input bit with_w, input int wpat);
    for (int k = 0; k < 32; k++) exp_q.push_back(fword(fpat, k));
    if (with_w) for (int i = 0; i < 192; i++) wexp_q.push_back(wval(wpat, i));
  endtask

  // Starts a run and watches it cycle by cycle (c = 1 is T+1).
  task automatic run_check(input bit skip, input int exp_done, input bit poke_wr,
                           input bit poke_start, input bit golden);
    int we_n, iv_n, done_c, done_n, last_iv, spacing_bad, busy_bad, err_n;
    int first_we, last_we, first_iv, beat_sum;
    logic [47:0] w, ew;
    logic [7:0]  eww;
    we_n = 0; iv_n = 0; done_c = -1; done_n = 0; last_iv = 0; spacing_bad = 0;
    busy_bad = 0; err_n = 0; first_we = -1; last_we = -1; first_iv = -1;
    start = 1'b1; skip_wload = skip;
    tick();
    start = 1'b0; skip_wload = 1'b0;
    for (int c = 1; c <= exp_done + 3; c++) begin
      if (weight_en) begin
        if (we_n == 0) first_we = c;
        last_we = c;
        we_n++;
        eww = (wexp_q.size() > 0) ? wexp_q.pop_front() : 8'hxx;
        chk("weight", weight, eww);
      end
      if (ivalid) begin
        if (iv_n == 0) first_iv = c;
        else if (c - last_iv != 2) spacing_bad++;
        last_iv = c;
        w  = {din_5, din_4, din_3, din_2, din_1, din_0};
        ew = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
        chk("din_word", w, ew);
        if (golden) begin
          beat_sum = 36 * iv_n - 561;  // all-ones weights: sum of 6k+c-96
          chk("fc_sum", sum6(w), beat_sum);
        end
        iv_n++;
      end
      if (done) begin
        if (done_n == 0) done_c = c;
        done_n++;
      end
      if (start_err) err_n++;
      if ((c <= exp_done) != busy) busy_bad++;
      feat_wr_en = poke_wr && (c == 5);
      wt_wr_en   = poke_wr && (c == 5);
      set_word(2, 0);
      wt_wr_data = 8'h7F;
      start      = poke_start && (c == 9);
      tick();
    end
    feat_wr_en = 1'b0; wt_wr_en = 1'b0; start = 1'b0;
    chk("weight_en_count", we_n, skip ? 0 : 192);
    if (!skip) begin
      chk("first_weight_cycle", first_we, 1);
      chk("last_weight_cycle", last_we, 192);
    end
    chk("ivalid_count", iv_n, 32);
    chk("first_beat_cycle", first_iv, skip ? 1 : 194);
    chk("beat_spacing_errs", spacing_bad, 0);
    chk("done_cycle", done_c, exp_done);
    chk("done_count", done_n, 1);
    chk("busy_errs", busy_bad, 0);
    chk("err_during_run", err_n, 0);
    chk("din_idle_zero", {din_5, din_4, din_3, din_2, din_1, din_0}, 48'h0);
    chk("feat_full_after", feat_full, 1'b0);
    chk("exp_left", exp_q.size() + wexp_q.size(), 0);
    exp_q.delete();
    wexp_q.delete();
  endtask

  // ---------------- start-acceptance vectors ----------------
  typedef struct {
    int n_feat;
    int n_wt;
    bit skip;
    bit exp_err;
    bit exp_we;
    bit exp_iv;
  } start_vec_t;

  start_vec_t tbl[7];

  initial begin
    int iv_n, done_n;
    tbl[0] = '{n_feat: 31, n_wt: 192, skip: 0, exp_err: 1, exp_we: 0, exp_iv: 0};
    tbl[1] = '{n_feat: 32, n_wt: 0,   skip: 0, exp_err: 1, exp_we: 0, exp_iv: 0};
    tbl[2] = '{n_feat: 32, n_wt: 191, skip: 0, exp_err: 1, exp_we: 0, exp_iv: 0};
    tbl[3] = '{n_feat: 32, n_wt: 0,   skip: 1, exp_err: 0, exp_we: 0, exp_iv: 1};
    tbl[4] = '{n_feat: 32, n_wt: 192, skip: 0, exp_err: 0, exp_we: 1, exp_iv: 0};
    tbl[5] = '{n_feat: 0,  n_wt: 192, skip: 1, exp_err: 1, exp_we: 0, exp_iv: 0};
    tbl[6] = '{n_feat: 31, n_wt: 0,   skip: 1, exp_err: 1, exp_we: 0, exp_iv: 0};

    feat_wr_en = 1'b0; wt_wr_en = 1'b0; start = 1'b0; skip_wload = 1'b0;
    wt_wr_data = '0; set_word(0, 0);
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_start_err", start_err, 1'b0);
    chk("rst_weight_en", weight_en, 1'b0);
    chk("rst_weight", weight, 8'h0);
    chk("rst_ivalid", ivalid, 1'b0);
    chk("rst_din", {din_5, din_4, din_3, din_2, din_1, din_0}, 48'h0);
    chk("rst_feat_full", feat_full, 1'b0);
    chk("rst_wt_full", wt_full, 1'b0);

    for (int t = 0; t < 7; t++) begin
      do_reset();
      fill_wts(0, tbl[t].n_wt, 0);
      fill_feats(0, tbl[t].n_feat, 0);
      chk("tbl_feat_full", feat_full, tbl[t].n_feat == 32);
      chk("tbl_wt_full", wt_full, tbl[t].n_wt == 192);
      start = 1'b1; skip_wload = tbl[t].skip;
      tick();
      start = 1'b0; skip_wload = 1'b0;
      chk("tbl_start_err", start_err, tbl[t].exp_err);
      chk("tbl_busy", busy, !tbl[t].exp_err);
      chk("tbl_weight_en", weight_en, tbl[t].exp_we);
      chk("tbl_ivalid", ivalid, tbl[t].exp_iv);
      tick();
      chk("tbl_start_err_t2", start_err, 1'b0);
      chk("tbl_busy_t2", busy, !tbl[t].exp_err);
    end

    // Write and start on the same edge: start sees the 31-word count.
    do_reset();
    fill_wts(0, 192, 0);
    fill_feats(0, 31, 0);
    feat_wr_en = 1'b1; set_word(0, 31); start = 1'b1;
    tick();
    feat_wr_en = 1'b0; start = 1'b0;
    chk("same_edge_err", start_err, 1'b1);
    chk("same_edge_busy", busy, 1'b0);
    chk("same_edge_full", feat_full, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("retry_busy", busy, 1'b1);
    chk("retry_weight_en", weight_en, 1'b1);

    // Full run with overfill and writes/start while busy.
    do_reset();
    fill_wts(0, 192, 0);
    fill_wts(192, 1, 2);
    fill_feats(0, 32, 0);
    fill_feats(32, 1, 2);
    chk("full_feat_full", feat_full, 1'b1);
    chk("full_wt_full", wt_full, 1'b1);
    push_exp(0, 1, 0);
    run_check(1'b0, 257, 1'b1, 1'b1, 1'b1);
    chk("wt_retained", wt_full, 1'b1);

    // Refill features only, skip the weight phase.
    fill_feats(0, 32, 1);
    push_exp(1, 0, 0);
    run_check(1'b1, 64, 1'b0, 1'b1, 1'b0);
    chk("wt_retained_skip", wt_full, 1'b1);

    // Reset in the middle of beat 10.
    fill_feats(0, 32, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    iv_n = 0;
    for (int c = 0; c < 400 && iv_n < 11; c++) begin
      if (ivalid) iv_n++;
      if (iv_n < 11) tick();
    end
    chk("beat10_reached", iv_n, 11);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ivalid", ivalid, 1'b0);
    chk("midrst_din", {din_5, din_4, din_3, din_2, din_1, din_0}, 48'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_weight_en", weight_en, 1'b0);
    chk("midrst_feat_full", feat_full, 1'b0);
    chk("midrst_wt_full", wt_full, 1'b0);
    tick();
    rst = 1'b0;
    done_n = 0;
    for (int c = 0; c < 120; c++) begin
      if (done || busy || ivalid) done_n++;
      tick();
    end
    chk("midrst_no_activity", done_n, 0);

    // Skip run with an empty weight buffer; a weight write while busy must drop.
    fill_feats(0, 32, 1);
    push_exp(1, 0, 0);
    run_check(1'b1, 64, 1'b1, 1'b0, 1'b0);
    fill_wts(0, 191, 1);
    chk("wt_191_not_full", wt_full, 1'b0);
    fill_wts(191, 1, 1);
    chk("wt_192_full", wt_full, 1'b1);

    // Fresh fill completes normally with a ramp of weights.
    fill_feats(0, 32, 0);
    push_exp(0, 1, 1);
    run_check(1'b0, 257, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_feeder.md
Name: fc_feeder

Overview:
- Transmitter side of the fully-connected layer input interface.
- Buffers one pooled feature vector (32 words × 6 signed 8-bit channels) and 192 signed 8-bit weights.
- On start: serially loads the weights into the fc block via weight_en/weight, then streams the 32 feature words on din_0..din_5 with ivalid pulsed every other cycle.
- Sits between the pooling stage / weight loader and the fc module, replacing the hand-driven stimulus currently used in fc bring-up.

Parameters:
- DATA_W, 8, width of each feature and weight value (signed).
- N_BEATS, 32, feature words per vector (6 values each).
- N_WEIGHTS, 192, weights serialised per run.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- feat_wr_en  in  1  write one 6-channel feature word into the buffer
- feat_wr_0..feat_wr_5  in  DATA_W each  feature word channels 0..5
- wt_wr_en  in  1  write one weight into the buffer
- wt_wr_data  in  DATA_W  weight value
- start  in  1  begin a weight-load + feed run
- skip_wload  in  1  sampled with start; 1 = skip weight phase (fc already holds weights)
- feat_full  out  1  feature buffer holds N_BEATS words
- wt_full  out  1  weight buffer holds N_WEIGHTS values
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- start_err  out  1  one-cycle pulse when start is rejected
- weight_en  out  1  weight strobe to fc
- weight  out  DATA_W  weight value to fc
- ivalid  out  1  feature word valid to fc
- din_0..din_5  out  DATA_W each  feature word to fc

Behaviour:
- Reset: all outputs 0; feature/weight counts cleared; state IDLE. Buffer contents are don't-care. A reset mid-run aborts immediately; no done pulse.
- All outputs are registered.
- Buffer writes are accepted only in IDLE:
  - Feature words land at address feat_cnt, then feat_cnt increments.
  - Weights land at address wt_cnt, then wt_cnt increments.
  - Writes when the corresponding buffer is full, or while busy, are dropped silently; counts stay put.
- feat_full = (feat_cnt == N_BEATS); wt_full = (wt_cnt == N_WEIGHTS).
- Start acceptance (start sampled high in IDLE = cycle T):
  - Accepted if feat_full, and also wt_full unless skip_wload = 1.
  - Otherwise start_err = 1 at T+1 and the block stays IDLE.
  - A write and a start on the same edge: start sees the pre-write counts.
  - start while busy is ignored; no error.
- FSM: IDLE -> LOAD_W (or FEED if skip_wload) -> SETTLE -> FEED <-> FEED_GAP -> FIN -> IDLE. busy = 1 from T+1 through FIN.
- LOAD_W:
  - weight_en = 1 for exactly N_WEIGHTS cycles, T+1..T+192.
  - weight = w[i] at T+1+i, in write order.
- SETTLE: one cycle, T+193, with weight_en = 0 and weight = 0.
- FEED:
  - Beat k (0..31) has ivalid = 1 for one cycle at T+194+2k, with din_0..din_5 = word k.
  - FEED_GAP cycles in between have ivalid = 0; din holds the last word.
  - With skip_wload, beat k is at T+1+2k instead.
- FIN:
  - Entered on the cycle after the last beat (its gap cycle).
  - done = 1 in that cycle (T+257 normally), then IDLE; din returns to 0.
- After done: feat_cnt clears to 0 (vector consumed). Weights and wt_cnt are retained, so a following run may reload them or skip.
- Signed values pass through unmodified; no arithmetic on data.

Test Plan:
- Write 192 weights all 1 and 32 words with word k channel c = 6k+c-96 (signed), then start. Required: weight_en high exactly 192 cycles with weight = 1; ivalid has 32 one-cycle pulses spaced 2 cycles apart; beat 31 carries 90..95; done once at T+257.
- start with only 31 feature words written -> start_err pulse at T+1; busy, weight_en and ivalid stay 0.
- Second run with skip_wload = 1 after refilling features only -> no weight_en; first ivalid at T+1; done at T+64.
- Extra writes beyond full (a 33rd word, a 193rd weight) and writes during busy -> counts saturate; streamed data is unchanged from the first-written values.
- Assert rst at beat 10 -> all outputs 0 the same cycle; feat_full and wt_full = 0; no done; a fresh fill + start completes normally.
- Drive the outputs into the fc module with the all-ones-weight vector -> fc dout matches the per-beat golden sums.
